// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage decode inputs and pipeline control outputs.
//   master: drives id_valid, id_instr, branch_taken, freeze, cnt_clear;
//           observes stall, bubble, flush_if, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt.
//   slave : the hazard controller itself.
// CNT_W must equal the CNT_W of the attached hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [15:0]      id_instr;
  logic             branch_taken;
  logic             freeze;
  logic             cnt_clear;
  logic             stall;
  logic             bubble;
  logic             flush_if;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_instr, branch_taken, freeze, cnt_clear,
    input  stall, bubble, flush_if, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_instr, branch_taken, freeze, cnt_clear,
    output stall, bubble, flush_if, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit, 8-register, 5-stage core.
// Decodes the ID instruction, tracks in-flight register writes in a 3-slot
// scoreboard (EX, MEM, WB) and drives stall/bubble, IF flush on a taken BZ,
// operand forward selects and saturating stall/flush performance counters.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - hazard_ctrl_if.slave (decode inputs, control outputs, counters)
module hazard_ctrl #(
  parameter int unsigned FORWARDING = 1,
  parameter int unsigned WB_BYPASS  = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [3:0] OpLd = 4'd10;
  localparam logic [3:0] OpSt = 4'd11;
  localparam logic [3:0] OpBz = 4'd12;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
    logic       ld;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, new_slot;

  logic [3:0] op;
  logic [2:0] rs1, rs2, dest;
  logic       writes, rd1, rd2;
  logic       hit_ex_a, hit_mem_a, hit_wb_a;
  logic       hit_ex_b, hit_mem_b, hit_wb_b;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Youngest producer wins; a WB match is invisible when the regfile bypasses it.
  function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit, logic wb_hit);
    if (ex_hit)                        return 2'd1;
    else if (mem_hit)                  return 2'd2;
    else if (wb_hit && WB_BYPASS == 0) return 2'd3;
    else                               return 2'd0;
  endfunction

  // Decode
  always_comb begin
    op     = bus.id_instr[15:12];
    dest   = bus.id_instr[11:9];
    rs1    = bus.id_instr[8:6];
    rs2    = (op == OpSt) ? bus.id_instr[11:9] : bus.id_instr[5:3];
    writes = bus.id_valid && (op >= 4'd1) && (op <= OpLd);
    rd1    = bus.id_valid && (op >= 4'd1) && (op <= OpBz);
    rd2    = bus.id_valid && (((op >= 4'd1) && (op <= 4'd8)) || (op == OpSt));
  end

  // Hazard detection and forwarding
  always_comb begin
    hit_ex_a  = rd1 && ex_q.v  && (ex_q.dest  == rs1);
    hit_mem_a = rd1 && mem_q.v && (mem_q.dest == rs1);
    hit_wb_a  = rd1 && wb_q.v  && (wb_q.dest  == rs1);
    hit_ex_b  = rd2 && ex_q.v  && (ex_q.dest  == rs2);
    hit_mem_b = rd2 && mem_q.v && (mem_q.dest == rs2);
    hit_wb_b  = rd2 && wb_q.v  && (wb_q.dest  == rs2);

    if (FORWARDING != 0) begin
      stall = (hit_ex_a || hit_ex_b) && ex_q.ld;
    end else begin
      stall = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b ||
              ((WB_BYPASS == 0) && (hit_wb_a || hit_wb_b));
    end

    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if ((FORWARDING != 0) && !stall) begin
      fwd_a = fwd_sel(hit_ex_a, hit_mem_a, hit_wb_a);
      fwd_b = fwd_sel(hit_ex_b, hit_mem_b, hit_wb_b);
    end

    // Stalled or squashed instructions enter EX as empty slots.
    new_slot.v    = writes && !stall && !bus.branch_taken;
    new_slot.dest = dest;
    new_slot.ld   = (op == OpLd);
  end

  always_comb begin
    bus.stall     = stall;
    bus.bubble    = stall;
    bus.flush_if  = bus.branch_taken && !stall;
    bus.fwd_a_sel = fwd_a;
    bus.fwd_b_sel = fwd_b;
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end

  // Counter next-state: clear beats increment, saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.freeze) begin
      if (bus.cnt_clear) begin
        stall_cnt_d = '0;
        flush_cnt_d = '0;
      end else begin
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
        if (bus.branch_taken && !stall && (flush_cnt_q != '1)) begin
          flush_cnt_d = flush_cnt_q + CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (!bus.freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= new_slot;
      end
    end
  end

endmodule
